// File: rtl/usb_tx_scheduler.sv
// USB TX packet scheduler: arbitrates handshake and DATA0 requests, launches one
// packet at a time into usb_tx, then enforces an inter-packet gap and a start timeout.
module usb_tx_scheduler #(
  parameter int unsigned IPG_CYCLES    = 16,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_req,
  input  logic [1:0] hs_type,
  input  logic       data_req,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       busy,
  output logic       hs_done,
  output logic       data_done,
  output logic       timeout_err,
  output logic       hs_overrun,
  output logic       data_empty_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WAIT_ACT = 3'd2;
  localparam logic [2:0] ACTIVE   = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  localparam logic [CNT_W-1:0] IPG_LIM = CNT_W'(IPG_CYCLES);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(START_TIMEOUT);

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             hs_pend, hs_pend_nxt;
  logic [1:0]       hs_type_reg, hs_type_nxt;
  logic             data_pend, data_pend_nxt;
  logic             cur_hs, cur_hs_nxt;
  logic             hs_take, data_take;
  logic             tx_start_nxt, busy_nxt, hs_done_nxt, data_done_nxt;
  logic             timeout_err_nxt, hs_overrun_nxt, data_empty_err_nxt;
  logic [1:0]       tx_packet_nxt;

  // Saturating increment shared by the timeout and gap phases.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // Next-state, request capture and registered-output decode.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    hs_pend_nxt        = hs_pend;
    hs_type_nxt        = hs_type_reg;
    data_pend_nxt      = data_pend;
    cur_hs_nxt         = cur_hs;
    tx_packet_nxt      = tx_packet;
    hs_take            = 1'b0;
    data_take          = 1'b0;
    hs_done_nxt        = 1'b0;
    data_done_nxt      = 1'b0;
    timeout_err_nxt    = 1'b0;
    hs_overrun_nxt     = 1'b0;
    data_empty_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (hs_pend) begin
          hs_take       = 1'b1;
          state_nxt     = START;
          cur_hs_nxt    = 1'b1;
          tx_packet_nxt = hs_type_reg;
        end else if (data_pend) begin
          data_take          = 1'b1;
          state_nxt          = START;
          cur_hs_nxt         = 1'b0;
          tx_packet_nxt      = 2'd0;
          data_empty_err_nxt = (buffer_occupancy == 7'd0);
        end
      end
      START: begin
        state_nxt = WAIT_ACT;
        cnt_nxt   = '0;
      end
      WAIT_ACT: begin
        if (tx_transfer_active) begin
          state_nxt = ACTIVE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc >= TO_LIM) begin
            state_nxt       = IDLE;
            timeout_err_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!tx_transfer_active) begin
          hs_done_nxt   = cur_hs;
          data_done_nxt = !cur_hs;
          state_nxt     = GAP;
          cnt_nxt       = '0;
        end
      end
      GAP: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc >= IPG_LIM) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A fresh request wins over the consume-clear so it is never lost.
    if (hs_take)   hs_pend_nxt   = 1'b0;
    if (data_take) data_pend_nxt = 1'b0;
    if (hs_req && (hs_type != 2'd0)) begin
      hs_overrun_nxt = hs_pend && !hs_take;
      hs_pend_nxt    = 1'b1;
      hs_type_nxt    = hs_type;
    end
    if (data_req) data_pend_nxt = 1'b1;

    tx_start_nxt = (state == IDLE) && (state_nxt == START);
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      hs_pend        <= 1'b0;
      hs_type_reg    <= 2'd0;
      data_pend      <= 1'b0;
      cur_hs         <= 1'b0;
      tx_start       <= 1'b0;
      tx_packet      <= 2'd0;
      busy           <= 1'b0;
      hs_done        <= 1'b0;
      data_done      <= 1'b0;
      timeout_err    <= 1'b0;
      hs_overrun     <= 1'b0;
      data_empty_err <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      hs_pend        <= hs_pend_nxt;
      hs_type_reg    <= hs_type_nxt;
      data_pend      <= data_pend_nxt;
      cur_hs         <= cur_hs_nxt;
      tx_start       <= tx_start_nxt;
      tx_packet      <= tx_packet_nxt;
      busy           <= busy_nxt;
      hs_done        <= hs_done_nxt;
      data_done      <= data_done_nxt;
      timeout_err    <= timeout_err_nxt;
      hs_overrun     <= hs_overrun_nxt;
      data_empty_err <= data_empty_err_nxt;
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: cycle vector table plus hand sequences for
// timeout, handshake overrun and mid-packet reset.
module tb_usb_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs_req;
  logic [1:0] hs_type;
  logic       data_req;
  logic [6:0] buffer_occupancy;
  logic       tx_transfer_active;
  logic       tx_start;
  logic [1:0] tx_packet;
  logic       busy, hs_done, data_done, timeout_err, hs_overrun, data_empty_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         rep;
    logic       hs;
    logic [1:0] ht;
    logic       dr;
    logic [6:0] occ;
    logic       act;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  usb_tx_scheduler #(.IPG_CYCLES(16), .START_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .hs_req(hs_req), .hs_type(hs_type), .data_req(data_req),
    .buffer_occupancy(buffer_occupancy), .tx_transfer_active(tx_transfer_active),
    .tx_start(tx_start), .tx_packet(tx_packet), .busy(busy), .hs_done(hs_done),
    .data_done(data_done), .timeout_err(timeout_err), .hs_overrun(hs_overrun),
    .data_empty_err(data_empty_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed output view: {tx_start, tx_packet, busy, hs_done, data_done, timeout_err, hs_overrun, data_empty_err}
  function automatic logic [8:0] outs();
    return {tx_start, tx_packet, busy, hs_done, data_done, timeout_err, hs_overrun, data_empty_err};
  endfunction

  function automatic logic [8:0] o(input logic st, input logic [1:0] pkt, input logic bz,
                                   input logic hd, input logic dd, input logic to,
                                   input logic ov, input logic em);
    return {st, pkt, bz, hd, dd, to, ov, em};
  endfunction

  task automatic add(input int rep, input logic hs, input logic [1:0] ht, input logic dr,
                     input logic [6:0] occ, input logic act, input logic [8:0] exp);
    vec_t v;
    v.rep = rep; v.hs = hs; v.ht = ht; v.dr = dr; v.occ = occ; v.act = act; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hs_req = 1'b0; hs_type = 2'd0; data_req = 1'b0;
  endtask

  int   nstart;
  logic [1:0] pkt_seen;
  logic stray;

  initial begin
    rst = 1'b1; idle_inputs(); buffer_occupancy = 7'd5; tx_transfer_active = 1'b0;
    tick(); tick();
    check("reset_outputs", outs(), 9'd0);
    rst = 1'b0;

    // ACK: active 3 cycles after tx_start, held 40 cycles
    add(1,  1, 2'd1, 0, 7'd5, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(1, 2'd1, 1, 0, 0, 0, 0, 0));
    add(3,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd1, 1, 0, 0, 0, 0, 0));
    add(40, 0, 2'd0, 0, 7'd5, 1, o(0, 2'd1, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd1, 1, 1, 0, 0, 0, 0));
    add(15, 0, 2'd0, 0, 7'd5, 0, o(0, 2'd1, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd1, 0, 0, 0, 0, 0, 0));
    add(2,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd1, 0, 0, 0, 0, 0, 0));
    // NAK and DATA0 requested together: NAK first, DATA0 18 cycles after active falls
    add(1,  1, 2'd2, 1, 7'd5, 0, o(0, 2'd1, 0, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(1, 2'd2, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 1, o(0, 2'd2, 1, 0, 0, 0, 0, 0));
    add(4,  0, 2'd0, 0, 7'd5, 1, o(0, 2'd2, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd2, 1, 1, 0, 0, 0, 0));
    add(15, 0, 2'd0, 0, 7'd5, 0, o(0, 2'd2, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd2, 0, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(1, 2'd0, 1, 0, 0, 0, 0, 0));
    add(2,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    add(2,  0, 2'd0, 0, 7'd5, 1, o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 1, 0, 1, 0, 0, 0));
    add(15, 0, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    // zero-length DATA0 still sent, flagged in the tx_start cycle
    add(1,  0, 2'd0, 1, 7'd0, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd0, 0, o(1, 2'd0, 1, 0, 0, 0, 0, 1));
    add(2,  0, 2'd0, 0, 7'd0, 1, o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd0, 0, o(0, 2'd0, 1, 0, 1, 0, 0, 0));
    add(15, 0, 2'd0, 0, 7'd0, 0, o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    add(1,  0, 2'd0, 0, 7'd0, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    // hs_type 0 is ignored
    add(1,  1, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    add(3,  0, 2'd0, 0, 7'd5, 0, o(0, 2'd0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        hs_req = (r == 0) ? vecs[i].hs : 1'b0;
        hs_type = vecs[i].ht;
        data_req = (r == 0) ? vecs[i].dr : 1'b0;
        buffer_occupancy = vecs[i].occ;
        tx_transfer_active = vecs[i].act;
        tick();
        check($sformatf("vec%0d_rep%0d", i, r), outs(), vecs[i].exp);
      end
    end
    idle_inputs(); buffer_occupancy = 7'd5; tx_transfer_active = 1'b0;

    // Start timeout: no active response
    data_req = 1'b1; tick(); data_req = 1'b0; tick();
    check("to_start", outs(), o(1, 2'd0, 1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("to_wait%0d", k), outs(), o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    end
    tick();
    check("to_err", outs(), o(0, 2'd0, 0, 0, 0, 1, 0, 0));
    tick();
    check("to_after", outs(), o(0, 2'd0, 0, 0, 0, 0, 0, 0));
    data_req = 1'b1; tick(); data_req = 1'b0; tick();
    check("to_retry_start", outs(), o(1, 2'd0, 1, 0, 0, 0, 0, 0));
    tx_transfer_active = 1'b1; tick(); tick();
    tx_transfer_active = 1'b0; tick();
    check("to_retry_done", outs(), o(0, 2'd0, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 16; k++) tick();
    check("to_retry_idle", outs(), o(0, 2'd0, 0, 0, 0, 0, 0, 0));

    // Handshake overrun while DATA0 is active
    data_req = 1'b1; tick(); data_req = 1'b0; tick();
    check("ov_start", outs(), o(1, 2'd0, 1, 0, 0, 0, 0, 0));
    tx_transfer_active = 1'b1; tick(); tick();
    hs_req = 1'b1; hs_type = 2'd1; tick();
    check("ov_first", outs(), o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    hs_req = 1'b0; tick();
    check("ov_between", outs(), o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    hs_req = 1'b1; hs_type = 2'd3; tick();
    check("ov_pulse", outs(), o(0, 2'd0, 1, 0, 0, 0, 1, 0));
    hs_req = 1'b0; hs_type = 2'd0; tick();
    check("ov_cleared", outs(), o(0, 2'd0, 1, 0, 0, 0, 0, 0));
    tx_transfer_active = 1'b0; tick();
    check("ov_data_done", outs(), o(0, 2'd0, 1, 0, 1, 0, 0, 0));
    nstart = 0; pkt_seen = 2'd0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (tx_start) begin nstart++; pkt_seen = tx_packet; end
    end
    check("ov_start_count", 9'(nstart), 9'd1);
    check("ov_stall_pkt", {7'd0, pkt_seen}, 9'd3);

    // Reset mid-ACTIVE with a handshake pending
    hs_req = 1'b1; hs_type = 2'd1; tick(); hs_req = 1'b0; tick();
    check("rs_start", outs(), o(1, 2'd1, 1, 0, 0, 0, 0, 0));
    tx_transfer_active = 1'b1; tick(); tick(); tick();
    hs_req = 1'b1; hs_type = 2'd2; tick();
    hs_req = 1'b0; hs_type = 2'd0; rst = 1'b1; tick();
    check("rs_outputs", outs(), 9'd0);
    rst = 1'b0; tx_transfer_active = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("rs_quiet%0d", k), {7'd0, tx_start, busy}, 9'd0);
    end
    hs_req = 1'b1; hs_type = 2'd2; tick(); hs_req = 1'b0; tick();
    check("rs_new_req", outs(), o(1, 2'd2, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 10; k++) tick();
    check("rs_new_timeout_idle", outs(), o(0, 2'd2, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
